dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  MEM-stage load/store unit between the pipeline and a valid/grant/response data bus.
//  Registers each load or store, drives one bus transaction, and formats load data
//  (byte/half extraction, sign/zero extension). Returns dmem_valid/dmem_ready to the
//  hazard unit, which stalls the pipeline while dmem_valid && !dmem_ready.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in ADDR+RESP before abort with fault; 0 disables timeout
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  mem_read      in   1   MEM-stage load
//  mem_write     in   1   MEM-stage store
//  funct3        in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  addr          in   32  byte address from ALU
//  wdata         in   32  store data, rs2 value, low-aligned
//  dmem_valid    out  1   combinational: mem_read | mem_write
//  dmem_ready    out  1   one-cycle completion pulse; pipeline advances this cycle
//  rdata         out  32  formatted load data; valid only while dmem_ready=1
//  lsu_misalign  out  1   with dmem_ready: misaligned address or illegal funct3
//  lsu_fault     out  1   with dmem_ready: bus_err or timeout
//  bus_req       out  1   request; held until bus_gnt
//  bus_we        out  1   1 = write
//  bus_addr      out  32  {addr[31:2],2'b00}
//  bus_wdata     out  32  lane-replicated store data
//  bus_wstrb     out  4   byte enables; 0000 on reads
//  bus_gnt       in   1   request accepted this cycle
//  bus_rvalid    in   1   response; required for both reads and writes
//  bus_rdata     in   32  read word
//  bus_err       in   1   error qualifier, sampled with bus_rvalid
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, all registered outputs 0, timeout counter 0.
//    Reset mid-transaction drops bus_req at once. No pending response is tracked.
//  FSM:
//  - IDLE: if mem_read|mem_write, latch inputs.
//    Misaligned or illegal: H/HU with addr[0]=1, W with addr[1:0]!=0,
//    funct3 011/110/111, BU/HU on store. These go to DONE with misalign=1 and no bus access.
//    Otherwise go to ADDR.
//  - ADDR: bus_req=1 with addr/we/wdata/wstrb stable. On bus_gnt go to RESP; bus_req=0 next cycle.
//  - RESP: on bus_rvalid capture formatted data and bus_err into lsu_fault, then go to DONE.
//  - DONE: dmem_ready=1 for exactly one cycle, then IDLE. No new request is accepted in DONE.
//  - Timeout: counter clears on leaving IDLE and counts in ADDR/RESP. On reaching TIMEOUT_CYCLES,
//    drop bus_req and go to DONE with lsu_fault=1, rdata=0. A later rvalid in IDLE is ignored.
//  Minimum latency with gnt/rvalid in their first cycle: request seen cycle 0, ADDR 1, RESP 2,
//    dmem_ready 3. Misaligned: dmem_ready at cycle 1.
//  Stores:
//  - B: wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
//  - H: wstrb = 0011<<{addr[1],1'b0}, wdata = {2{wdata[15:0]}}.
//  - W: wstrb = 1111.
//  Loads: select byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend.
//    On fault or misalign, rdata=0.
//  Both mem_read and mem_write high: treated as a load; the write is ignored.
//  Handshake: inputs must stay stable while dmem_valid && !dmem_ready (guaranteed by the stall).
//    Logic uses the latched copies only. bus_gnt outside ADDR and bus_rvalid outside RESP are ignored.
//  rdata, lsu_misalign and lsu_fault are 0 whenever dmem_ready=0.
// TESTING
//  - LB addr=0x1003, bus_rdata=0x80FF_0000, gnt+rvalid immediate -> ready at cycle 3,
//    rdata=0xFFFF_FF80, wstrb=0000.
//  - SH addr=0x2002 wdata=0x1234_ABCD -> bus_addr=0x2000, wstrb=1100,
//    bus_wdata=0xABCD_ABCD, ready after rvalid.
//  - LW addr=0x3001 -> no bus_req, ready at cycle 1, misalign=1, rdata=0.
//  - bus_gnt held low 5 cycles -> bus_req high all 5 cycles with stable addr,
//    dmem_ready stays 0 the whole time.
//  - TIMEOUT_CYCLES=8, no rvalid -> ready 1 cycle, fault=1; a late rvalid is ignored.
//  - rst_n pulsed low in RESP -> outputs 0 immediately; the next LHU (addr 0x2, rdata 0xF00D_0000)
//    gives rdata=0x0000_F00D.

Source files
------------

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store unit. Registers one load or store,
// runs a single request/grant/response bus transaction, and returns formatted
// load data together with a one-cycle completion pulse.
//
// Handshake: dmem_valid is high while the pipeline presents a load or store.
// The pipeline stalls while dmem_valid && !dmem_ready and advances in the
// single cycle where dmem_ready=1. On the bus, bus_req is held until a cycle
// with bus_gnt. Exactly one bus_rvalid then completes the transaction, for
// reads and writes alike.
module dmem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dmem_valid,
    output logic        dmem_ready,
    output logic [31:0] rdata,
    output logic        lsu_misalign,
    output logic        lsu_fault,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RESP, S_DONE} state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        misalign_q, misalign_d;
    logic        fault_q, fault_d;
    logic [31:0] tmo_q, tmo_d;

    logic        bad_req;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [31:0] ld_data;
    logic [31:0] ld_shift;
    logic [15:0] ld_half;
    logic        tmo_hit;

    // Alignment / legality of the request presented in IDLE.
    always_comb begin
        bad_req = 1'b0;
        case (funct3)
            3'b000:  bad_req = 1'b0;
            3'b001:  bad_req = addr[0];
            3'b010:  bad_req = |addr[1:0];
            3'b100:  bad_req = !mem_read;
            3'b101:  bad_req = !mem_read | addr[0];
            default: bad_req = 1'b1;
        endcase
    end

    // Store byte enables and lane-replicated write data.
    always_comb begin
        st_strb = 4'b1111;
        st_data = wdata;
        case (funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << addr[1:0];
                st_data = {4{wdata[7:0]}};
            end
            2'b01: begin
                st_strb = 4'b0011 << {addr[1], 1'b0};
                st_data = {2{wdata[15:0]}};
            end
            default: begin
                st_strb = 4'b1111;
                st_data = wdata;
            end
        endcase
    end

    // Load lane selection and sign/zero extension from the latched request.
    always_comb begin
        ld_shift = bus_rdata >> {addr_q[1:0], 3'b000};
        ld_half  = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_shift[7:0]};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    // Last permitted cycle of ADDR+RESP; a zero limit disables the abort.
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q >= 32'(TIMEOUT_CYCLES - 1));

    // Next-state and datapath capture for the transaction FSM.
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        f3_d       = f3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        misalign_d = misalign_q;
        fault_d    = fault_q;
        tmo_d      = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (mem_read | mem_write) begin
                    // A simultaneous read and write is a load.
                    we_d       = mem_write & ~mem_read;
                    f3_d       = funct3;
                    addr_d     = addr;
                    wdata_d    = (mem_write & ~mem_read) ? st_data : 32'h0;
                    wstrb_d    = (mem_write & ~mem_read) ? st_strb : 4'b0000;
                    rdata_d    = 32'h0;
                    fault_d    = 1'b0;
                    tmo_d      = 32'h0;
                    misalign_d = bad_req;
                    state_d    = bad_req ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                tmo_d = tmo_q + 32'd1;
                if (tmo_hit) begin
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                    state_d = S_DONE;
                end else if (bus_gnt) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                tmo_d = tmo_q + 32'd1;
                if (bus_rvalid) begin
                    fault_d = bus_err;
                    rdata_d = (bus_err | we_q) ? 32'h0 : ld_data;
                    state_d = S_DONE;
                end else if (tmo_hit) begin
                    fault_d = 1'b1;
                    rdata_d = 32'h0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                misalign_d = 1'b0;
                fault_d    = 1'b0;
                rdata_d    = 32'h0;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and latched request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            rdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            tmo_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            f3_q       <= f3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
            tmo_q      <= tmo_d;
        end
    end

    assign dmem_valid   = mem_read | mem_write;
    assign dmem_ready   = (state_q == S_DONE);
    assign rdata        = dmem_ready ? rdata_q : 32'h0;
    assign lsu_misalign = dmem_ready & misalign_q;
    assign lsu_fault    = dmem_ready & fault_q;
    assign bus_req      = (state_q == S_ADDR);
    assign bus_we       = we_q;
    assign bus_addr     = {addr_q[31:2], 2'b00};
    assign bus_wdata    = wdata_q;
    assign bus_wstrb    = wstrb_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed transactions push their expected
// completion {misalign, fault, rdata} into exp_q; a negedge monitor pops and
// compares whenever dmem_ready is seen.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        dmem_valid, dmem_ready;
    logic [31:0] rdata;
    logic        lsu_misalign, lsu_fault;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;
    logic [1:0]  dbg_state;

    logic [33:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    // Clock
    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
        .addr(addr), .wdata(wdata),
        .dmem_valid(dmem_valid), .dmem_ready(dmem_ready), .rdata(rdata),
        .lsu_misalign(lsu_misalign), .lsu_fault(lsu_fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .bus_err(bus_err), .dbg_state(dbg_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ready", 64'd1, 64'd0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("resp", 64'({lsu_misalign, lsu_fault, rdata}), 64'(e));
                end
            end else begin
                check("idle_outputs_zero", 64'({lsu_misalign, lsu_fault, rdata}), 64'd0);
            end
        end
    end

    // One transaction with gnt after gnt_wait cycles and rvalid right after.
    task automatic run_txn(input string name, input logic rd, input logic wr,
                           input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rword, input logic err, input int gnt_wait,
                           input logic exp_bus, input logic [3:0] exp_strb,
                           input logic [31:0] exp_bwd, input logic [33:0] exp_resp);
        exp_q.push_back(exp_resp);
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
        @(negedge clk);
        check({name, "_valid"}, 64'(dmem_valid), 64'd1);
        check({name, "_req_c0"}, 64'(bus_req), 64'd0);
        @(posedge clk);
        if (exp_bus) begin
            for (int i = 0; i < gnt_wait; i++) begin
                #1;
                bus_gnt = 1'b0;
                bus_rvalid = (i == 0);   // stray response in ADDR must be ignored
                bus_rdata = 32'hBAD0_BAD0;
                @(negedge clk);
                check({name, "_stall_req"}, 64'(bus_req), 64'd1);
                check({name, "_stall_addr"}, 64'(bus_addr), 64'({a[31:2], 2'b00}));
                check({name, "_stall_ready"}, 64'(dmem_ready), 64'd0);
                @(posedge clk);
            end
            #1;
            bus_rvalid = 1'b0;
            bus_gnt = 1'b1;
            @(negedge clk);
            check({name, "_req"}, 64'(bus_req), 64'd1);
            check({name, "_addr"}, 64'(bus_addr), 64'({a[31:2], 2'b00}));
            check({name, "_we"}, 64'(bus_we), 64'(wr & ~rd));
            check({name, "_wstrb"}, 64'(bus_wstrb), 64'(exp_strb));
            if (wr & ~rd) check({name, "_wdata"}, 64'(bus_wdata), 64'(exp_bwd));
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = rword; bus_err = err;
            @(negedge clk);
            check({name, "_req_resp"}, 64'(bus_req), 64'd0);
            check({name, "_ready_resp"}, 64'(dmem_ready), 64'd0);
            @(posedge clk); #1;
            bus_rvalid = 1'b0; bus_err = 1'b0;
        end
        @(negedge clk);
        check({name, "_ready_latency"}, 64'(dmem_ready), 64'd1);
        check({name, "_req_done"}, 64'(bus_req), 64'd0);
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        bit seen;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
        addr = 32'h0; wdata = 32'h0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        bus_rdata = 32'h0; bus_err = 1'b0;
        #3;
        check("rst_state", 64'(dbg_state), 64'd0);
        check("rst_ready", 64'(dmem_ready), 64'd0);
        check("rst_req", 64'(bus_req), 64'd0);
        check("rst_outs", 64'({bus_we, bus_wstrb, bus_addr, bus_wdata}), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        //       name         rd wr f3      addr          wdata         rword         err wait bus strb     bwdata        {mis,flt,rdata}
        run_txn("lb",        1, 0, 3'b000, 32'h0000_1003, 32'h0,        32'h80FF_0000, 0, 0, 1, 4'b0000, 32'h0,        {2'b00, 32'hFFFF_FF80});
        run_txn("sh",        0, 1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 0, 1, 4'b1100, 32'hABCD_ABCD, {2'b00, 32'h0});
        run_txn("lw_mis",    1, 0, 3'b010, 32'h0000_3001, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        {2'b10, 32'h0});
        run_txn("lw_stall",  1, 0, 3'b010, 32'h0000_4000, 32'h0,        32'hCAFE_BABE, 0, 5, 1, 4'b0000, 32'h0,        {2'b00, 32'hCAFE_BABE});
        run_txn("sb",        0, 1, 3'b000, 32'h0000_5001, 32'h0000_00A5, 32'h0,        0, 0, 1, 4'b0010, 32'hA5A5_A5A5, {2'b00, 32'h0});
        run_txn("lh",        1, 0, 3'b001, 32'h0000_6002, 32'h0,        32'h8001_7FFF, 0, 0, 1, 4'b0000, 32'h0,        {2'b00, 32'hFFFF_8001});
        run_txn("lbu",       1, 0, 3'b100, 32'h0000_7001, 32'h0,        32'h1234_F0AB, 0, 0, 1, 4'b0000, 32'h0,        {2'b00, 32'h0000_00F0});
        run_txn("lw_err",    1, 0, 3'b010, 32'h0000_8000, 32'h0,        32'h1111_1111, 1, 0, 1, 4'b0000, 32'h0,        {2'b01, 32'h0});
        run_txn("sw",        0, 1, 3'b010, 32'h0000_9000, 32'h0102_0304, 32'h0,        0, 0, 1, 4'b1111, 32'h0102_0304, {2'b00, 32'h0});
        run_txn("ill_f3",    1, 0, 3'b011, 32'h0000_A000, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        {2'b10, 32'h0});
        run_txn("sbu_ill",   0, 1, 3'b100, 32'h0000_A001, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        {2'b10, 32'h0});
        run_txn("rd_wr",     1, 1, 3'b010, 32'h0000_B000, 32'hFFFF_FFFF, 32'h55AA_55AA, 0, 0, 1, 4'b0000, 32'h0,       {2'b00, 32'h55AA_55AA});
        run_txn("lh_mis",    1, 0, 3'b001, 32'h0000_C001, 32'h0,        32'h0,         0, 0, 0, 4'b0000, 32'h0,        {2'b10, 32'h0});
        run_txn("lb_pos",    1, 0, 3'b000, 32'h0000_D000, 32'h0,        32'h0000_007F, 0, 0, 1, 4'b0000, 32'h0,        {2'b00, 32'h0000_007F});
        run_txn("lhu_lo",    1, 0, 3'b101, 32'h0000_E000, 32'h0,        32'h1234_8765, 0, 0, 1, 4'b0000, 32'h0,        {2'b00, 32'h0000_8765});

        // Timeout: gnt at once, rvalid never; 8 cycles in ADDR+RESP -> ready at cycle 9.
        exp_q.push_back({2'b01, 32'h0});
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_0100;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        cyc = 2;
        seen = 1'b0;
        while (!seen && cyc < 30) begin
            @(negedge clk);
            if (dmem_ready) seen = 1'b1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        check("timeout_latency", 64'(cyc), 64'd9);
        @(posedge clk); #1;
        mem_read = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("late_rvalid_state", 64'(dbg_state), 64'd0);
            check("late_rvalid_ready", 64'(dmem_ready), 64'd0);
        end

        // Reset while waiting in RESP.
        @(posedge clk); #1;
        mem_read = 1'b1; funct3 = 3'b101; addr = 32'h0000_0002;
        @(posedge clk); #1;
        bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_gnt = 1'b0;
        check("pre_rst_state", 64'(dbg_state), 64'd2);
        #2;
        rst_n = 1'b0;
        mem_read = 1'b0;
        #1;
        check("mid_rst_req", 64'(bus_req), 64'd0);
        check("mid_rst_state", 64'(dbg_state), 64'd0);
        check("mid_rst_outs", 64'({dmem_ready, lsu_misalign, lsu_fault, rdata}), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_txn("lhu_after_rst", 1, 0, 3'b101, 32'h0000_0002, 32'h0, 32'hF00D_0000, 0, 0, 1, 4'b0000, 32'h0, {2'b00, 32'h0000_F00D});

        repeat (3) @(posedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
